// File: rtl/hazard3_reset_ctrl.sv
// Reset sequencer: turns Debug Module hart/system reset requests (and power-on
// reset) into stretched reset outputs, acknowledging only after reset-sync feedback confirms a full cycle.
module hazard3_reset_ctrl #(
  parameter int N_HARTS        = 1,
  parameter int ASSERT_CYCLES  = 4,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sys_reset_req,
  output logic               sys_reset_done,
  input  logic [N_HARTS-1:0] hart_reset_req,
  output logic [N_HARTS-1:0] hart_reset_done,
  output logic               sys_rst_n_out,
  output logic [N_HARTS-1:0] hart_rst_n_out,
  input  logic               sys_rst_n_fb,
  input  logic [N_HARTS-1:0] hart_rst_n_fb
);

  // Channel 0 is the system channel, channel i+1 is hart i.
  localparam int NCH  = N_HARTS + 1;
  localparam int CMAX = (ASSERT_CYCLES > RELEASE_CYCLES) ? ASSERT_CYCLES : RELEASE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] A_LAST = CW'(ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] R_LAST = CW'((RELEASE_CYCLES == 0) ? 0 : RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Per-channel state is kept in named arrays so checkers can bind to it directly.
  state_t          chan_state_q [NCH];
  state_t          chan_state_d [NCH];
  logic [CW-1:0]   cnt_q        [NCH];
  logic [CW-1:0]   cnt_d        [NCH];
  logic            by_req_q     [NCH];
  logic            by_req_d     [NCH];

  logic [NCH-1:0]  req;
  logic [NCH-1:0]  fb;

  assign req = {hart_reset_req, sys_reset_req};
  assign fb  = {hart_rst_n_fb, sys_rst_n_fb};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        chan_state_q[c] <= ST_ASSERT;
        cnt_q[c]        <= '0;
        by_req_q[c]     <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        chan_state_q[c] <= chan_state_d[c];
        cnt_q[c]        <= cnt_d[c];
        by_req_q[c]     <= by_req_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      chan_state_d[c] = chan_state_q[c];
      cnt_d[c]        = cnt_q[c];
      by_req_d[c]     = by_req_q[c];
      case (chan_state_q[c])
        ST_IDLE: begin
          if (req[c]) begin
            chan_state_d[c] = ST_ASSERT;
            cnt_d[c]        = '0;
            by_req_d[c]     = 1'b1;
          end
        end
        ST_ASSERT: begin
          // Only cycles where the synchronised reset is seen low count.
          if (fb[c]) begin
            cnt_d[c] = '0;
          end else if (cnt_q[c] == A_LAST) begin
            chan_state_d[c] = ST_RELEASE;
            cnt_d[c]        = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (!fb[c]) begin
            cnt_d[c] = '0;
          end else if (cnt_q[c] >= R_LAST) begin
            // Power-on and aborted sequences end silently in IDLE.
            chan_state_d[c] = (by_req_q[c] && req[c]) ? ST_DONE : ST_IDLE;
            cnt_d[c]        = '0;
            by_req_d[c]     = 1'b0;
          end else begin
            cnt_d[c] = cnt_q[c] + CW'(1);
          end
        end
        ST_DONE: begin
          if (!req[c]) begin
            chan_state_d[c] = ST_IDLE;
          end
        end
        default: begin
          chan_state_d[c] = ST_IDLE;
        end
      endcase
    end
  end

  assign sys_rst_n_out  = (chan_state_q[0] != ST_ASSERT);
  assign sys_reset_done = (chan_state_q[0] == ST_DONE);

  // A system reset also holds every hart in reset.
  for (genvar i = 0; i < N_HARTS; i++) begin : g_hart
    assign hart_rst_n_out[i]  = !((chan_state_q[i+1] == ST_ASSERT) || (chan_state_q[0] == ST_ASSERT));
    assign hart_reset_done[i] = (chan_state_q[i+1] == ST_DONE);
  end

endmodule

// File: tb/tb_hazard3_reset_ctrl.sv
// Directed bench for hazard3_reset_ctrl: per-cycle vector table plus hand-written
// sequences; feedback is modelled as a 2-cycle-delayed copy of each reset output.
module tb_hazard3_reset_ctrl;

  localparam int N_HARTS = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               sys_reset_req;
  logic               sys_reset_done;
  logic [N_HARTS-1:0] hart_reset_req;
  logic [N_HARTS-1:0] hart_reset_done;
  logic               sys_rst_n_out;
  logic [N_HARTS-1:0] hart_rst_n_out;
  logic               sys_rst_n_fb;
  logic [N_HARTS-1:0] hart_rst_n_fb;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- clock / reset-sync model ----------------
  always #5 clk = ~clk;

  logic               sys_d1 = 1'b0;
  logic               sys_d2 = 1'b0;
  logic [N_HARTS-1:0] hart_d1 = '0;
  logic [N_HARTS-1:0] hart_d2 = '0;
  logic [N_HARTS-1:0] fb_force_hi = '0;

  always @(posedge clk) begin
    sys_d1  <= sys_rst_n_out;
    sys_d2  <= sys_d1;
    hart_d1 <= hart_rst_n_out;
    hart_d2 <= hart_d1;
  end

  assign sys_rst_n_fb  = sys_d2;
  assign hart_rst_n_fb = hart_d2 | fb_force_hi;

  hazard3_reset_ctrl #(
    .N_HARTS       (N_HARTS),
    .ASSERT_CYCLES (4),
    .RELEASE_CYCLES(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sys_reset_req  (sys_reset_req),
    .sys_reset_done (sys_reset_done),
    .hart_reset_req (hart_reset_req),
    .hart_reset_done(hart_reset_done),
    .sys_rst_n_out  (sys_rst_n_out),
    .hart_rst_n_out (hart_rst_n_out),
    .sys_rst_n_fb   (sys_rst_n_fb),
    .hart_rst_n_fb  (hart_rst_n_fb)
  );

  // ---------------- vector table ----------------
  typedef struct packed {
    logic               rst;
    logic               sreq;
    logic [N_HARTS-1:0] hreq;
    logic               sn;
    logic [N_HARTS-1:0] hn;
    logic               sd;
    logic [N_HARTS-1:0] hd;
  } vec_t;

  localparam int OW = 2 + 2 * N_HARTS;

  vec_t          vecs[$];
  logic [OW-1:0] exp_q[$];

  task automatic add(input int n, input logic r, input logic s, input logic [N_HARTS-1:0] h,
                     input logic sn, input logic [N_HARTS-1:0] hn, input logic sd,
                     input logic [N_HARTS-1:0] hd);
    vec_t v;
    v.rst = r; v.sreq = s; v.hreq = h; v.sn = sn; v.hn = hn; v.sd = sd; v.hd = hd;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] observed();
    return {sys_rst_n_out, hart_rst_n_out, sys_reset_done, hart_reset_done};
  endfunction

  task automatic check(input string name, input int idx, input logic [OW-1:0] exp);
    logic [OW-1:0] got;
    got = observed();
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s[%0d]: got {sn,hn,sd,hd}=%b expected %b", name, idx, got, exp);
    end
  endtask

  // Power-on stretch, hart reset, back-to-back request, abort, system reset.
  task automatic build_table();
    add(3, 1, 0, 2'b00, 0, 2'b00, 0, 2'b00);
    add(3, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00);
    add(7, 0, 0, 2'b00, 1, 2'b11, 0, 2'b00);
    add(6, 0, 0, 2'b01, 1, 2'b10, 0, 2'b00);
    add(4, 0, 0, 2'b01, 1, 2'b11, 0, 2'b00);
    add(4, 0, 0, 2'b01, 1, 2'b11, 0, 2'b01);
    add(1, 0, 0, 2'b00, 1, 2'b11, 0, 2'b00);
    add(6, 0, 0, 2'b01, 1, 2'b10, 0, 2'b00);
    add(4, 0, 0, 2'b01, 1, 2'b11, 0, 2'b00);
    add(1, 0, 0, 2'b01, 1, 2'b11, 0, 2'b01);
    add(1, 0, 0, 2'b00, 1, 2'b11, 0, 2'b00);
    add(2, 0, 0, 2'b01, 1, 2'b10, 0, 2'b00);
    add(4, 0, 0, 2'b00, 1, 2'b10, 0, 2'b00);
    add(6, 0, 0, 2'b00, 1, 2'b11, 0, 2'b00);
    add(6, 0, 1, 2'b00, 0, 2'b00, 0, 2'b00);
    add(4, 0, 1, 2'b00, 1, 2'b11, 0, 2'b00);
    add(2, 0, 1, 2'b00, 1, 2'b11, 1, 2'b00);
    add(1, 0, 0, 2'b00, 1, 2'b11, 0, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [OW-1:0] e;
    logic          a, b;

    rst = 1'b1;
    sys_reset_req = 1'b0;
    hart_reset_req = '0;

    build_table();
    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].rst;
      sys_reset_req  = vecs[i].sreq;
      hart_reset_req = vecs[i].hreq;
      exp_q.push_back({vecs[i].sn, vecs[i].hn, vecs[i].sd, vecs[i].hd});
      step();
      check("table", i, exp_q.pop_front());
    end

    // Overlapping system and hart-1 requests, hart 1 starting 3 cycles later.
    sys_reset_req = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      step();
      a = (t >= 1 && t <= 6);
      b = (t >= 1 && t <= 7);
      e = {!a, !b, !a, (t >= 11), (t >= 12), 1'b0};
      check("overlap", t, e);
      if (t == 3) hart_reset_req[1] = 1'b1;
    end
    sys_reset_req = 1'b0;
    hart_reset_req = '0;
    step();
    check("overlap_drop", 0, {1'b1, 2'b11, 1'b0, 2'b00});

    // Feedback stuck high: hart 0 must stay in reset with no timeout.
    fb_force_hi[0] = 1'b1;
    hart_reset_req[0] = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      step();
      check("fb_stuck", t, {1'b1, 2'b10, 1'b0, 2'b00});
    end
    fb_force_hi[0] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      step();
      e = {1'b1, 1'b1, !(t <= 3), 1'b0, 1'b0, (t >= 8)};
      check("fb_unstuck", t, e);
    end
    hart_reset_req = '0;
    step();
    check("fb_unstuck_drop", 0, {1'b1, 2'b11, 1'b0, 2'b00});

    // rst pulsed while hart 0 is in RELEASE with its request still high.
    hart_reset_req[0] = 1'b1;
    repeat (7) step();
    check("mid_release", 0, {1'b1, 2'b11, 1'b0, 2'b00});
    rst = 1'b1;
    step();
    check("mid_rst", 0, {1'b0, 2'b00, 1'b0, 2'b00});
    rst = 1'b0;
    for (int t = 1; t <= 21; t++) begin
      step();
      a = (t <= 5);
      b = a || (t >= 11 && t <= 16);
      e = {!a, !a, !b, 1'b0, 1'b0, (t >= 21)};
      check("post_rst", t, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
